// File: rtl/debouncer.sv
// Debouncer for a bouncing level input (e.g. a push button).
// A new input level must be sampled on STABLE_COUNT consecutive clock edges
// before the registered output `clean` follows it. One-cycle `rise` / `fall`
// strobes mark each change of `clean`.
// Optional feature: define DEBOUNCER_SYNC_EN to pass `signal` through a
// two-flop synchronizer first (adds exactly 2 cycles of latency). Without it,
// `signal` must already be synchronous to clk.
module debouncer #(
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic signal,
  output logic clean,
  output logic rise,
  output logic fall
);

  // Reject configurations the counter cannot represent.
  if ((STABLE_COUNT < 1) ||
      (64'(STABLE_COUNT) > ((64'd1 << CNT_WIDTH) - 64'd1))) begin : g_cfg_err
    $error("debouncer: STABLE_COUNT must lie in 1 .. 2^CNT_WIDTH-1");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam bit                   BYPASS   = (STABLE_COUNT == 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic s;

`ifdef DEBOUNCER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Shift the raw input through two flops to settle metastability.
  always_comb begin
    sync_d = {sync_q[0], signal};
  end

  // Synchronizer register.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= sync_d;
  end

  assign s = sync_q[1];
`else
  assign s = signal;
`endif

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clean_q, clean_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  // Next-state logic: qualify a new level, drop back to the stable state on any bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    unique case (state_q)
      LOW: begin
        if (s) begin
          if (BYPASS) begin
            state_d = HIGH;
            clean_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = WAIT_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          clean_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          if (BYPASS) begin
            state_d = LOW;
            clean_d = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = WAIT_LOW;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          clean_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
        clean_d = 1'b0;
      end
    endcase
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer with STABLE_COUNT=4. Expected edge counts are
// shifted by the synchronizer latency when DEBOUNCER_SYNC_EN is defined.
module tb_debouncer;

  localparam int N = 4;
`ifdef DEBOUNCER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signal = 1'b0;
  logic clean, rise, fall;

  int n_assert = 0;
  int n_fail   = 0;

  debouncer #(.STABLE_COUNT(N), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .signal(signal),
    .clean (clean),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one input sample, let one rising edge pass, then check the outputs.
  task automatic step(input logic sig, input logic ec, input logic er,
                      input logic ef, input string tag);
    signal = sig;
    @(posedge clk);
    #1;
    chk({tag, ".clean"}, clean, ec);
    chk({tag, ".rise"},  rise,  er);
    chk({tag, ".fall"},  fall,  ef);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    signal = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, "reset");
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_reset");

    // Clean rise after N consecutive high samples
    for (int i = 1; i <= N + LAT; i++)
      step(1'b1, (i >= N + LAT), (i == N + LAT), 1'b0, "rise_hold");
    step(1'b1, 1'b1, 1'b0, 1'b0, "rise_after");

    // Clean fall after N consecutive low samples, then a second low run
    for (int i = 1; i <= N + LAT; i++)
      step(1'b0, !(i >= N + LAT), 1'b0, (i == N + LAT), "fall_hold");
    for (int i = 1; i <= 6; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, "fall_again");

    // Short pulse of N-1 cycles is rejected
    for (int i = 1; i <= N - 1; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, "short_hi");
    for (int i = 1; i <= N + LAT; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, "short_lo");

    // Bounce 1,0,1,1,0 then held high: only the final four 1s qualify
    step(1'b1, 1'b0, 1'b0, 1'b0, "bounce0");
    step(1'b0, 1'b0, 1'b0, 1'b0, "bounce1");
    step(1'b1, 1'b0, 1'b0, 1'b0, "bounce2");
    step(1'b1, 1'b0, 1'b0, 1'b0, "bounce3");
    step(1'b0, 1'b0, 1'b0, 1'b0, "bounce4");
    for (int i = 1; i <= N + LAT + 1; i++)
      step(1'b1, (i >= N + LAT), (i == N + LAT), 1'b0, "bounce_tail");

    // Return low to set up the reset scenario
    for (int i = 1; i <= N + LAT; i++)
      step(1'b0, !(i >= N + LAT), 1'b0, (i == N + LAT), "back_low");
    for (int i = 1; i <= 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, "settle_low");

    // Reset mid-qualification restarts the count; held-high input rises once
    step(1'b1, 1'b0, 1'b0, 1'b0, "pre_rst1");
    step(1'b1, 1'b0, 1'b0, 1'b0, "pre_rst2");
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
    rst = 1'b0;
    for (int i = 1; i <= N + LAT + 2; i++)
      step(1'b1, (i >= N + LAT), (i == N + LAT), 1'b0, "rst_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 The block SHALL provide parameter STABLE_COUNT, default 50000, giving the consecutive cycles the input must hold a new level before the output follows (1 ms at 50 MHz).
REQ-002 The block SHALL provide parameter CNT_WIDTH, default 16, giving the width of the stability counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port signal, input, 1 bit: raw, asynchronous, bouncing level (e.g. push button).
REQ-006 Port clean, output, 1 bit: registered debounced level; this feeds the downstream single-pulse stage.
REQ-007 Port rise, output, 1 bit: registered one-cycle strobe when clean goes 0->1.
REQ-008 Port fall, output, 1 bit: registered one-cycle strobe when clean goes 1->0.

Function
REQ-009 The block SHALL derive a sampled input s from signal (see Configuration); all debounce decisions SHALL use s only.
REQ-010 The FSM SHALL have four states: LOW (clean=0, stable), WAIT_HIGH (clean=0, s=1 being qualified), HIGH (clean=1, stable) and WAIT_LOW (clean=1, s=0 being qualified).
REQ-011 LOW->WAIT_HIGH on an edge sampling s=1, with counter loaded to 1; HIGH->WAIT_LOW on an edge sampling s=0, with counter loaded to 1.
REQ-012 In WAIT_x, each edge sampling the new level SHALL increment the counter; each edge sampling the old level SHALL return to the stable state with counter cleared (bounce rejection).
REQ-013 clean SHALL toggle, and the FSM enter the opposite stable state, on the edge that takes the STABLE_COUNT-th consecutive sample of the new level; the counter SHALL clear on that edge.
REQ-014 With STABLE_COUNT=1, the stable state SHALL transition directly to the opposite stable state (WAIT_x bypassed), so clean changes on the first edge sampling the new level.
REQ-015 rise SHALL be 1 exactly on the cycle after the edge where clean goes 0->1, and fall exactly on the cycle after the edge where clean goes 1->0; otherwise both SHALL be 0, and they are never both 1.
REQ-016 The counter SHALL never exceed STABLE_COUNT and SHALL never wrap.
REQ-017 Legal configurations SHALL satisfy 1 <= STABLE_COUNT <= 2^CNT_WIDTH-1; the block SHALL stop elaboration with an error otherwise.
REQ-018 A pulse on s shorter than STABLE_COUNT cycles SHALL produce no change on clean, rise or fall.

Reset
REQ-019 While rst=1 at a clock edge: state=LOW, counter=0, clean=0, rise=0, fall=0 and synchronizer flops=0.
REQ-020 Reset asserted mid-qualification SHALL abandon the qualification; after release, a held-high input SHALL need a full STABLE_COUNT samples again.
REQ-021 On the first edge after rst deasserts, the block SHALL operate normally.
REQ-022 If signal is high across reset release, clean SHALL rise after the normal latency and produce one rise strobe.

Configuration
REQ-023 Macro DEBOUNCER_SYNC_EN defined: s SHALL be the output of a two-flop synchronizer on signal, adding exactly 2 cycles of latency.
REQ-024 Macro DEBOUNCER_SYNC_EN undefined: s SHALL be signal directly, with no added latency; signal is then required to be synchronous to clk.

Verification
REQ-025 STABLE_COUNT=4, macro undefined: signal 0->1 held; clean=1 and FSM=HIGH on the 4th edge sampling 1, and rise=1 for one cycle after that edge.
REQ-026 STABLE_COUNT=4: signal high for 3 cycles then low -> clean, rise and fall stay 0 throughout.
REQ-027 STABLE_COUNT=4: bounce pattern 1,0,1,1,0,1,1,1,1 -> clean rises only after the final four 1s; exactly one rise strobe.
REQ-028 STABLE_COUNT=4, clean=1: signal low for 4 cycles -> clean=0 and one fall strobe; a second low run produces no further strobe.
REQ-029 STABLE_COUNT=4: rst=1 for one edge after 2 high samples, signal held high -> clean rises 4 edges after reset release.
REQ-030 Macro defined, STABLE_COUNT=4 -> every clean transition occurs exactly 2 cycles later than in REQ-025 to REQ-029.
